top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameters SHALL be: IQ_BW, default 32, packed I+Q sample width; IorQ_BW, default 16, I or Q sample width (IQ_BW = 2*IorQ_BW); C_S_AXI_CTRL_ADDR_WIDTH, default 6; C_S_AXI_CTRL_DATA_WIDTH, default 32.
REQ-002 Ports SHALL be:
- samp_clk  in  1  sole clock.
- samp_rst  in  1  asynchronous, active-high reset.
- iq_out_TVALID  out  1  sample valid.
- iq_out_TREADY  in  1  sink ready.
- iq_out_TDATA  out  IQ_BW  {I[31:16], Q[15:0]}, two's complement Q1.14.
- s_axi_ctrl_AWVALID/AWREADY  in/out  1 each; s_axi_ctrl_AWADDR  in  6.
- s_axi_ctrl_WVALID/WREADY  in/out  1 each; s_axi_ctrl_WDATA  in  32; s_axi_ctrl_WSTRB  in  4.
- s_axi_ctrl_BVALID/BREADY  out/in  1 each; s_axi_ctrl_BRESP  out  2.
- s_axi_ctrl_ARVALID/ARREADY  in/out  1 each; s_axi_ctrl_ARADDR  in  6.
- s_axi_ctrl_RVALID/RREADY  out/in  1 each; s_axi_ctrl_RDATA  out  32; s_axi_ctrl_RRESP  out  2.
REQ-003 The block SHALL have one clock (samp_clk); reset (samp_rst) SHALL be asynchronous and active-high.

Function
REQ-004 Register map (byte addresses) SHALL be: 0x00 CTRL, bit0 RUN, R/W; 0x04 MOD_TYPE[2:0], R/W; 0x08 SEED[14:0], R/W, loaded into LFSR on RUN 0->1; 0x0C SYMBOL_COUNT[31:0], RO, counts stream handshakes, cleared on RUN 0->1.
REQ-005 MOD_TYPE encoding SHALL be: 000 QPSK (2 bits/symbol), 001 BPSK (1), 010 QAM16 (4), 011 8PSK (3); writes of 100-111 SHALL be ignored, register unchanged, BRESP OKAY.
REQ-006 AXI-lite write: AWREADY and WREADY SHALL assert together for one cycle when AWVALID and WVALID are both high and no B response is pending; BVALID SHALL assert the next cycle and hold until BREADY; WSTRB byte lanes SHALL be honoured.
REQ-007 AXI-lite read: ARREADY SHALL pulse when ARVALID is high and no R response is pending; RVALID SHALL assert the next cycle and hold, with RDATA stable, until RREADY.
REQ-008 Unmapped addresses SHALL return SLVERR (2'b10); reads of them SHALL return 0; writes to them and to 0x0C SHALL be discarded.
REQ-009 Bit source SHALL be a PRBS-15 LFSR (x^15+x^14+1) advanced k bits per symbol; the first bit generated SHALL be the symbol MSB; a zero SEED SHALL be replaced by 15'h0001.
REQ-010 Mapping (A=16384, B=11585):
- BPSK: b=0 -> (+A,0), b=1 -> (-A,0).
- QPSK: I=b1?-B:+B, Q=b0?-B:+B.
- 8PSK: index n -> angle n*45 deg, components from {0,±B,±A}.
- QAM16: Gray levels 00->-12288, 01->-4096, 11->+4096, 10->+12288; I from b3b2, Q from b1b0.
REQ-011 While RUN=1, TVALID SHALL be high continuously, starting no later than 2 cycles after RUN is set; TDATA SHALL be held stable while TVALID && !TREADY.
REQ-012 A new symbol SHALL be presented the cycle after each handshake, giving 1 symbol/cycle throughput under constant TREADY.
REQ-013 A MOD_TYPE change SHALL take effect only on the first symbol generated after the write completes; the in-flight symbol SHALL never change.
REQ-014 Clearing RUN SHALL drop TVALID only after the pending sample handshakes; no sample SHALL be truncated.

Reset
REQ-015 On samp_rst, and until it is released:
- TVALID, AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0.
- TDATA, RDATA and all registers SHALL be 0, except SEED, which SHALL be 15'h0001.
- BRESP and RRESP SHALL be 2'b00.

Configuration
REQ-016 With macro TOP_QAM16_EN defined, QAM16 SHALL be supported; without it, the QAM16 mapper SHALL be omitted and MOD_TYPE writes of 010 SHALL be ignored, like codes 100-111.

Structure
REQ-017 A shared package SHALL hold the MOD_TYPE encodings, register offsets, constants A/B/QAM levels and the response codes OKAY/SLVERR.
REQ-018 One sub-module, symbol_mapper (LFSR bits + mod type -> I/Q, combinational), SHALL be instantiated; the AXI-lite slave and stream control SHALL stay in top.

Verification
REQ-019 Reset, then read 0x04 and 0x08 -> RDATA 0 and 1, RRESP OKAY, TVALID 0.
REQ-020 Write MOD_TYPE=1, CTRL=1, TREADY=1 -> every sample has Q=0 and I in {16384,-16384}; 200 cycles give SYMBOL_COUNT≈200.
REQ-021 Switch to MOD_TYPE=2 mid-run -> subsequent I,Q in {±4096,±12288}; MOD_TYPE=3 -> |I|,|Q| in {0,11585,16384}.
REQ-022 Random TREADY (about 50%) -> TDATA unchanged across every stall cycle; SYMBOL_COUNT equals the handshakes counted by the bench.
REQ-023 Read 0x20 -> RRESP 2'b10, RDATA 0; write 0x0C -> BRESP SLVERR, count unaffected; write MOD_TYPE=5 -> readback unchanged.

Source files
------------

// File: rtl/top_pkg.sv
// Shared definitions for the PRBS modulation source: modulation codes,
// register offsets, constellation amplitudes and AXI response codes.
// Build option: define TOP_QAM16_EN to include the QAM16 mapper.
package top_pkg;

    typedef enum logic [2:0] {
        MOD_QPSK  = 3'b000,
        MOD_BPSK  = 3'b001,
        MOD_QAM16 = 3'b010,
        MOD_8PSK  = 3'b011
    } mod_type_e;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_MOD_TYPE = 6'h04;
    localparam logic [5:0] ADDR_SEED     = 6'h08;
    localparam logic [5:0] ADDR_COUNT    = 6'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Q1.14 amplitudes: A = 1.0, B = cos(45 deg), QAM16 inner/outer levels
    localparam int AMP_A  = 16384;
    localparam int AMP_B  = 11585;
    localparam int QAM_LO = 4096;
    localparam int QAM_HI = 12288;

    localparam logic [14:0] SEED_DEFAULT = 15'h0001;

    // Only codes with a mapper in this build may be written to MOD_TYPE
    function automatic logic mod_supported(input logic [2:0] code);
        case (code)
            3'b000, 3'b001, 3'b011: return 1'b1;
`ifdef TOP_QAM16_EN
            3'b010:                 return 1'b1;
`endif
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/symbol_mapper.sv
// Combinational symbol mapper: draws k bits from the PRBS-15 state
// (first bit = symbol MSB), maps them to I/Q and returns the advanced state.
// Build option: define TOP_QAM16_EN to include the QAM16 mapper.
module symbol_mapper
    import top_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [14:0]  lfsr,
    input  mod_type_e    mod_type,
    output logic [W-1:0] i_val,
    output logic [W-1:0] q_val,
    output logic [14:0]  next_lfsr
);

    logic [14:0] stage [0:4];
    logic [3:0]  bits;

    function automatic logic [W-1:0] lvl(input int v);
        return W'(v);
    endfunction

`ifdef TOP_QAM16_EN
    // Gray-coded level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
    function automatic logic [W-1:0] qam_level(input logic [1:0] g);
        case (g)
            2'b00:   return lvl(-QAM_HI);
            2'b01:   return lvl(-QAM_LO);
            2'b11:   return lvl(QAM_LO);
            default: return lvl(QAM_HI);
        endcase
    endfunction
`else
    logic unused_qam;
    assign unused_qam = &{1'b0, bits[0], stage[4]};
`endif

    // Unroll four LFSR steps (x^15 + x^14 + 1); bits[3] is the first bit out
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
        stage[0] = lfsr;
        bits     = '0;
        for (int n = 0; n < 4; n++) begin
            bits[3-n]  = stage[n][14] ^ stage[n][13];
            stage[n+1] = {stage[n][13:0], bits[3-n]};
        end
    end

    // Map the leading k bits to a constellation point and pick the state after k steps
    always_comb begin
        i_val     = '0;
        q_val     = '0;
        next_lfsr = lfsr;
        case (mod_type)
            MOD_BPSK: begin
                i_val     = bits[3] ? lvl(-AMP_A) : lvl(AMP_A);
                next_lfsr = stage[1];
            end
            MOD_QPSK: begin
                i_val     = bits[3] ? lvl(-AMP_B) : lvl(AMP_B);
                q_val     = bits[2] ? lvl(-AMP_B) : lvl(AMP_B);
                next_lfsr = stage[2];
            end
            MOD_8PSK: begin
                case (bits[3:1])
                    3'd0: begin i_val = lvl(AMP_A);  q_val = lvl(0);      end
                    3'd1: begin i_val = lvl(AMP_B);  q_val = lvl(AMP_B);  end
                    3'd2: begin i_val = lvl(0);      q_val = lvl(AMP_A);  end
                    3'd3: begin i_val = lvl(-AMP_B); q_val = lvl(AMP_B);  end
                    3'd4: begin i_val = lvl(-AMP_A); q_val = lvl(0);      end
                    3'd5: begin i_val = lvl(-AMP_B); q_val = lvl(-AMP_B); end
                    3'd6: begin i_val = lvl(0);      q_val = lvl(-AMP_A); end
                    default: begin i_val = lvl(AMP_B); q_val = lvl(-AMP_B); end
                endcase
                next_lfsr = stage[3];
            end
`ifdef TOP_QAM16_EN
            MOD_QAM16: begin
                i_val     = qam_level(bits[3:2]);
                q_val     = qam_level(bits[1:0]);
                next_lfsr = stage[4];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/top.sv
// PRBS-driven I/Q symbol source with an AXI-lite control slave and an
// AXI-stream sample output (one symbol per cycle under constant TREADY).
// Build option: define TOP_QAM16_EN to include the QAM16 mapper.
module top
    import top_pkg::*;
#(
    parameter int IQ_BW                   = 32,
    parameter int IorQ_BW                 = 16,
    parameter int C_S_AXI_CTRL_ADDR_WIDTH = 6,
    parameter int C_S_AXI_CTRL_DATA_WIDTH = 32
) (
    input  logic                                 samp_clk,
    input  logic                                 samp_rst,
    output logic                                 iq_out_TVALID,
    input  logic                                 iq_out_TREADY,
    output logic [IQ_BW-1:0]                     iq_out_TDATA,
    input  logic                                 s_axi_ctrl_AWVALID,
    output logic                                 s_axi_ctrl_AWREADY,
    input  logic [C_S_AXI_CTRL_ADDR_WIDTH-1:0]   s_axi_ctrl_AWADDR,
    input  logic                                 s_axi_ctrl_WVALID,
    output logic                                 s_axi_ctrl_WREADY,
    input  logic [C_S_AXI_CTRL_DATA_WIDTH-1:0]   s_axi_ctrl_WDATA,
    input  logic [C_S_AXI_CTRL_DATA_WIDTH/8-1:0] s_axi_ctrl_WSTRB,
    output logic                                 s_axi_ctrl_BVALID,
    input  logic                                 s_axi_ctrl_BREADY,
    output logic [1:0]                           s_axi_ctrl_BRESP,
    input  logic                                 s_axi_ctrl_ARVALID,
    output logic                                 s_axi_ctrl_ARREADY,
    input  logic [C_S_AXI_CTRL_ADDR_WIDTH-1:0]   s_axi_ctrl_ARADDR,
    output logic                                 s_axi_ctrl_RVALID,
    input  logic                                 s_axi_ctrl_RREADY,
    output logic [C_S_AXI_CTRL_DATA_WIDTH-1:0]   s_axi_ctrl_RDATA,
    output logic [1:0]                           s_axi_ctrl_RRESP
);

    localparam int AW = C_S_AXI_CTRL_ADDR_WIDTH;
    localparam int DW = C_S_AXI_CTRL_DATA_WIDTH;
    localparam logic [AW-1:0] A_CTRL  = AW'(ADDR_CTRL);
    localparam logic [AW-1:0] A_MOD   = AW'(ADDR_MOD_TYPE);
    localparam logic [AW-1:0] A_SEED  = AW'(ADDR_SEED);
    localparam logic [AW-1:0] A_COUNT = AW'(ADDR_COUNT);

    logic              run;
    mod_type_e         mod_type;
    logic [14:0]       seed;
    logic [31:0]       count;
    logic [14:0]       lfsr;
    logic [14:0]       lfsr_next;
    logic [IorQ_BW-1:0] map_i, map_q;
    logic              wr_fire, rd_fire, run_rise, gen;
    logic [DW-1:0]     rd_data;
    logic [1:0]        rd_resp;

    assign wr_fire  = s_axi_ctrl_AWVALID && s_axi_ctrl_AWREADY && s_axi_ctrl_WVALID && s_axi_ctrl_WREADY;
    assign rd_fire  = s_axi_ctrl_ARVALID && s_axi_ctrl_ARREADY;
    assign run_rise = wr_fire && (s_axi_ctrl_AWADDR == A_CTRL) && s_axi_ctrl_WSTRB[0]
                      && s_axi_ctrl_WDATA[0] && !run;
    // A new symbol is built whenever the output slot is empty or being drained
    assign gen      = run && (!iq_out_TVALID || iq_out_TREADY);

    logic unused_bits;
    assign unused_bits = &{1'b0, s_axi_ctrl_WDATA[DW-1:15], s_axi_ctrl_WSTRB[DW/8-1:2]};

    symbol_mapper #(.W(IorQ_BW)) u_mapper (
        .lfsr      (lfsr),
        .mod_type  (mod_type),
        .i_val     (map_i),
        .q_val     (map_q),
        .next_lfsr (lfsr_next)
    );

    // AXI-lite write channel and the writable control registers
    always_ff @(posedge samp_clk or posedge samp_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (samp_rst) begin
            s_axi_ctrl_AWREADY <= 1'b0;
            s_axi_ctrl_WREADY  <= 1'b0;
            s_axi_ctrl_BVALID  <= 1'b0;
            s_axi_ctrl_BRESP   <= RESP_OKAY;
            run                <= 1'b0;
            mod_type           <= MOD_QPSK;
            seed               <= SEED_DEFAULT;
        end else begin
            s_axi_ctrl_AWREADY <= 1'b0;
            s_axi_ctrl_WREADY  <= 1'b0;
            if (s_axi_ctrl_BVALID && s_axi_ctrl_BREADY)
                s_axi_ctrl_BVALID <= 1'b0;
            if (wr_fire) begin
                s_axi_ctrl_BVALID <= 1'b1;
                s_axi_ctrl_BRESP  <= RESP_OKAY;
                case (s_axi_ctrl_AWADDR)
                    A_CTRL: if (s_axi_ctrl_WSTRB[0]) run <= s_axi_ctrl_WDATA[0];
                    A_MOD:  if (s_axi_ctrl_WSTRB[0] && mod_supported(s_axi_ctrl_WDATA[2:0]))
                                mod_type <= mod_type_e'(s_axi_ctrl_WDATA[2:0]);
                    A_SEED: begin
                        if (s_axi_ctrl_WSTRB[0]) seed[7:0]  <= s_axi_ctrl_WDATA[7:0];
                        if (s_axi_ctrl_WSTRB[1]) seed[14:8] <= s_axi_ctrl_WDATA[14:8];
                    end
                    default: s_axi_ctrl_BRESP <= RESP_SLVERR;
                endcase
            end else if (s_axi_ctrl_AWVALID && s_axi_ctrl_WVALID && !s_axi_ctrl_AWREADY
                         && !s_axi_ctrl_BVALID) begin
                s_axi_ctrl_AWREADY <= 1'b1;
                s_axi_ctrl_WREADY  <= 1'b1;
            end
        end
    end

    // Read-data multiplexer; unmapped offsets return zero with SLVERR
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_axi_ctrl_ARADDR)
            A_CTRL:  rd_data = DW'(run);
            A_MOD:   rd_data = DW'(mod_type);
            A_SEED:  rd_data = DW'(seed);
            A_COUNT: rd_data = DW'(count);
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // AXI-lite read channel: one outstanding read, data held until RREADY
    always_ff @(posedge samp_clk or posedge samp_rst) begin
        if (samp_rst) begin
            s_axi_ctrl_ARREADY <= 1'b0;
            s_axi_ctrl_RVALID  <= 1'b0;
            s_axi_ctrl_RDATA   <= '0;
            s_axi_ctrl_RRESP   <= RESP_OKAY;
        end else begin
            s_axi_ctrl_ARREADY <= 1'b0;
            if (s_axi_ctrl_RVALID && s_axi_ctrl_RREADY)
                s_axi_ctrl_RVALID <= 1'b0;
            if (rd_fire) begin
                s_axi_ctrl_RVALID <= 1'b1;
                s_axi_ctrl_RDATA  <= rd_data;
                s_axi_ctrl_RRESP  <= rd_resp;
            end else if (s_axi_ctrl_ARVALID && !s_axi_ctrl_ARREADY && !s_axi_ctrl_RVALID) begin
                s_axi_ctrl_ARREADY <= 1'b1;
            end
        end
    end

    // Stream output, LFSR and handshake counter; a stalled sample is never replaced or dropped
    always_ff @(posedge samp_clk or posedge samp_rst) begin
        if (samp_rst) begin
            iq_out_TVALID <= 1'b0;
            iq_out_TDATA  <= '0;
            lfsr          <= SEED_DEFAULT;
            count         <= '0;
        end else begin
            if (run_rise)
                lfsr <= (seed == 15'd0) ? SEED_DEFAULT : seed;
            else if (gen)
                lfsr <= lfsr_next;

            if (gen) begin
                iq_out_TVALID <= 1'b1;
                iq_out_TDATA  <= {map_i, map_q};
            end else if (iq_out_TREADY) begin
                iq_out_TVALID <= 1'b0;
            end

            if (run_rise)
                count <= '0;
            else if (iq_out_TVALID && iq_out_TREADY)
                count <= count + 32'd1;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed testbench for top: register access, BPSK/QAM16/8PSK streams,
// MOD_TYPE switching, random back-pressure and error responses.
module tb_top;

    logic        samp_clk = 1'b0;
    logic        samp_rst;
    logic        iq_out_TVALID, iq_out_TREADY;
    logic [31:0] iq_out_TDATA;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [5:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;

    always #5 samp_clk = ~samp_clk;

    top dut (
        .samp_clk           (samp_clk),
        .samp_rst           (samp_rst),
        .iq_out_TVALID      (iq_out_TVALID),
        .iq_out_TREADY      (iq_out_TREADY),
        .iq_out_TDATA       (iq_out_TDATA),
        .s_axi_ctrl_AWVALID (awvalid),
        .s_axi_ctrl_AWREADY (awready),
        .s_axi_ctrl_AWADDR  (awaddr),
        .s_axi_ctrl_WVALID  (wvalid),
        .s_axi_ctrl_WREADY  (wready),
        .s_axi_ctrl_WDATA   (wdata),
        .s_axi_ctrl_WSTRB   (wstrb),
        .s_axi_ctrl_BVALID  (bvalid),
        .s_axi_ctrl_BREADY  (bready),
        .s_axi_ctrl_BRESP   (bresp),
        .s_axi_ctrl_ARVALID (arvalid),
        .s_axi_ctrl_ARREADY (arready),
        .s_axi_ctrl_ARADDR  (araddr),
        .s_axi_ctrl_RVALID  (rvalid),
        .s_axi_ctrl_RREADY  (rready),
        .s_axi_ctrl_RDATA   (rdata),
        .s_axi_ctrl_RRESP   (rresp)
    );

    // Independent count of stream handshakes
    always @(posedge samp_clk)
        if (!samp_rst && iq_out_TVALID && iq_out_TREADY) hs_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(negedge samp_clk); n++; end while (!(awready && wready) && n < 50);
        check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
        @(posedge samp_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge samp_clk); n++; end
        check("bvalid", {31'd0, bvalid}, 32'd1);
        r = bresp;
        @(posedge samp_clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge samp_clk); n++; end while (!arready && n < 50);
        check("arready", {31'd0, arready}, 32'd1);
        @(posedge samp_clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge samp_clk); n++; end
        check("rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata; r = rresp;
        @(posedge samp_clk); #1;
        rready = 1'b0;
    endtask

    function automatic int iabs(input logic signed [15:0] v);
        return (v < 0) ? -int'(v) : int'(v);
    endfunction

    function automatic logic is_8psk(input logic [31:0] s);
        int ai, aq;
        ai = iabs(s[31:16]);
        aq = iabs(s[15:0]);
        return (ai == 11585 && aq == 11585) || (ai == 16384 && aq == 0) || (ai == 0 && aq == 16384);
    endfunction

    function automatic logic is_qam(input logic signed [15:0] v);
        return v == 16'sd4096 || v == -16'sd4096 || v == 16'sd12288 || v == -16'sd12288;
    endfunction

    initial begin
        logic [31:0] d, held, prev, cnt_before;
        logic [1:0]  r;
        logic        stalled;
        int          idx, base;

        samp_rst = 1'b1;
        iq_out_TREADY = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(posedge samp_clk);
        @(negedge samp_clk);
        check("rst_tvalid", {31'd0, iq_out_TVALID}, 32'd0);
        check("rst_tdata", iq_out_TDATA, 32'd0);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_bv_rv", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        @(posedge samp_clk); #1;
        samp_rst = 1'b0;

        // Reset values of the register file
        axi_read(6'h04, d, r);  check("mod_rst", d, 32'd0);  check("mod_rresp", {30'd0, r}, 32'd0);
        axi_read(6'h08, d, r);  check("seed_rst", d, 32'd1); check("seed_rresp", {30'd0, r}, 32'd0);
        check("idle_tvalid", {31'd0, iq_out_TVALID}, 32'd0);

        // Byte strobes: only the low byte of SEED changes
        axi_write(6'h08, 32'h0000ABCD, 4'b0001, r);
        axi_read(6'h08, d, r);  check("seed_strb", d, 32'h000000CD);
        // Zero seed is stored as-is but behaves like 15'h0001 in the LFSR
        axi_write(6'h08, 32'h0, 4'b1111, r);
        axi_read(6'h08, d, r);  check("seed_zero", d, 32'd0);

        // BPSK run; seed 1 gives thirteen 0 bits then a 1
        axi_write(6'h04, 32'd1, 4'b1111, r);  check("mod1_bresp", {30'd0, r}, 32'd0);
        axi_write(6'h00, 32'd1, 4'b1111, r);
        base = hs_count;
        check("run_tvalid", {31'd0, iq_out_TVALID}, 32'd1);
        check("first_sym", iq_out_TDATA, 32'h40000000);
        iq_out_TREADY = 1'b1;
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge samp_clk);
            check("tvalid_hi", {31'd0, iq_out_TVALID}, 32'd1);
            if (idx < 14)
                check("bpsk_seq", iq_out_TDATA, (idx == 13) ? 32'hC0000000 : 32'h40000000);
            check("bpsk_set", {31'd0, iq_out_TDATA == 32'h40000000 || iq_out_TDATA == 32'hC0000000}, 32'd1);
            idx++;
            @(posedge samp_clk); #1;
        end

        // Mid-run switch to QAM16 (ignored when QAM16 is not built)
        axi_write(6'h04, 32'd2, 4'b1111, r);  check("mod2_bresp", {30'd0, r}, 32'd0);
        for (int c = 0; c < 50; c++) begin
            @(negedge samp_clk);
`ifdef TOP_QAM16_EN
            check("qam_set", {31'd0, is_qam(iq_out_TDATA[31:16]) && is_qam(iq_out_TDATA[15:0])}, 32'd1);
`else
            check("bpsk_kept", {31'd0, iq_out_TDATA == 32'h40000000 || iq_out_TDATA == 32'hC0000000}, 32'd1);
`endif
            @(posedge samp_clk); #1;
        end
        axi_read(6'h04, d, r);
`ifdef TOP_QAM16_EN
        check("mod2_rb", d, 32'd2);
`else
        check("mod2_rb", d, 32'd1);
`endif

        // Switch to 8PSK while stalled: the held sample must not change
        iq_out_TREADY = 1'b0;
        @(posedge samp_clk); #1;
        held = iq_out_TDATA;
        axi_write(6'h04, 32'd3, 4'b1111, r);
        check("inflight_hold", iq_out_TDATA, held);
        iq_out_TREADY = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge samp_clk);
            if (c == 0) check("inflight_sent", iq_out_TDATA, held);
            else        check("8psk_set", {31'd0, is_8psk(iq_out_TDATA)}, 32'd1);
            @(posedge samp_clk); #1;
        end

        // Random back-pressure: data stays stable across every stall
        stalled = 1'b0; prev = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge samp_clk);
            if (stalled) check("stall_hold", iq_out_TDATA, prev);
            stalled = iq_out_TVALID && !iq_out_TREADY;
            prev = iq_out_TDATA;
            @(posedge samp_clk); #1;
            iq_out_TREADY = 1'($urandom_range(0, 1));
        end
        iq_out_TREADY = 1'b0;
        @(posedge samp_clk); #1;
        axi_read(6'h0C, d, r);  check("count_run", d, 32'(hs_count - base));

        // Clearing RUN while stalled keeps the pending sample until it is taken
        held = iq_out_TDATA;
        axi_write(6'h00, 32'd0, 4'b1111, r);
        @(posedge samp_clk); #1;
        check("stop_hold_v", {31'd0, iq_out_TVALID}, 32'd1);
        check("stop_hold_d", iq_out_TDATA, held);
        iq_out_TREADY = 1'b1;
        @(posedge samp_clk); #1;
        check("stop_drop", {31'd0, iq_out_TVALID}, 32'd0);
        iq_out_TREADY = 1'b0;
        axi_read(6'h0C, d, r);  check("count_stop", d, 32'(hs_count - base));
        cnt_before = d;

        // Error responses and ignored writes
        axi_read(6'h20, d, r);  check("unmap_rdata", d, 32'd0); check("unmap_rresp", {30'd0, r}, 32'd2);
        axi_write(6'h0C, 32'h1234, 4'b1111, r);  check("count_wr_bresp", {30'd0, r}, 32'd2);
        axi_read(6'h0C, d, r);  check("count_kept", d, cnt_before);
        axi_write(6'h04, 32'd5, 4'b1111, r);  check("mod5_bresp", {30'd0, r}, 32'd0);
        axi_read(6'h04, d, r);  check("mod5_rb", d, 32'd3);
        axi_read(6'h00, d, r);  check("ctrl_rb", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
